serial_alu_sequencer: RTL and testbench
=======================================

# serial_alu_sequencer

Bit-serial ALU controller that walks the 4-bit select of two 16:1 operand multiplexers and computes one result bit per step with a registered carry. It drives `sl` to the operand-A and operand-B `mux16` instances, consumes their single-bit outputs, and accumulates the 16-bit result. It also emits each result bit with its index, so a downstream `demux16` can scatter it. It fills the role of the step counter the ALU datapath has been missing.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 1: extra cycles `sl` is held before sampling, to cover NOR-gate mux propagation. Range 0..7.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a 16-bit operation; accepted only in IDLE
- `op`  in  2  operation: 00 ADD, 01 SUB, 10 XOR, 11 AND; captured on start
- `a_bit`  in  1  operand-A mux output for current `sl`
- `b_bit`  in  1  operand-B mux output for current `sl`
- `sl`  out  4  select to both operand muxes and the result demux
- `busy`  out  1  high from accept until the cycle before `done`
- `res_bit`  out  1  result bit for current `sl`
- `res_valid`  out  1  one-cycle strobe when `res_bit` is sampled
- `done`  out  1  one-cycle pulse; result, flags and `cout` are final
- `result`  out  16  accumulated result, held until next accepted start
- `cout`  out  1  final carry (ADD), not-borrow (SUB), 0 otherwise
- `zero`  out  1  result == 0 (see Configuration)
- `ovf`  out  1  signed overflow, ADD/SUB only (see Configuration)

## Operation

- States: IDLE, RUN, DONE.
- IDLE + `start`=1 → RUN. Capture `op`; `sl`=0; settle counter=0; `result`, `cout`, `zero`, `ovf` cleared. Carry register loads 1 for SUB, else 0.
- `start` in RUN or DONE is ignored; there is no queueing.
- RUN:
  - Each `sl` value is held SETTLE_CYCLES+1 cycles.
  - On the last cycle of the hold, sample `a_bit`/`b_bit` and compute the bit via sub-module. ADD: sum/carry of a,b,c. SUB: same with b inverted. XOR: a^b. AND: a&b.
  - Write `result[sl]`; assert `res_valid` and `res_bit` combinationally in that cycle; update carry.
  - At the bit-15 sample, also record carry-into-MSB for `ovf`. Then RUN → DONE; otherwise increment `sl`.
- DONE lasts exactly one cycle: `done`=1, `busy`=0, `sl` holds 15. Then → IDLE with `sl` returning to 0.
- `sl` never wraps inside an operation; 15→0 happens only via DONE→IDLE.
- Upstream must hold the mux data inputs stable while `busy`=1. The block does not check this.
- Reset (async, any state): state IDLE; all outputs 0, including `sl`, `result`, `done`, `busy`, `res_valid`, `cout`, `zero` and `ovf`. The settle counter and carry are also cleared. A reset mid-RUN discards the partial result.

## Timing

- Accept edge = t. `busy` is high from t+1.
- Bit i is sampled at edge t+(i+1)(SETTLE_CYCLES+1).
- `done` is high in cycle t+16(SETTLE_CYCLES+1)+1.
  - SETTLE_CYCLES=0: done at t+17.
  - SETTLE_CYCLES=1: done at t+33.
- `result`, `cout`, `zero` and `ovf` are registered and valid in the `done` cycle.
- The earliest next accept is the cycle after `done`.

## Configuration

- `SERIAL_ALU_FLAGS_EN` defined:
  - `zero` = (result==0), updated at the bit-15 sample.
  - `ovf` = carry-into-MSB ^ carry-out for ADD/SUB, 0 for XOR/AND.
- Not defined: `zero` and `ovf` ports remain but are tied to 0, and the MSB-carry register is removed.

## Structure

- Package `serial_alu_pkg`:
  - `WIDTH`=16 and `SEL_W`=4 constants.
  - `alu_op_t` enum (ADD, SUB, XOR, AND).
  - `seq_state_t` enum (IDLE, RUN, DONE).
- Sub-module `serial_bit_alu`: combinational one-bit slice. Inputs a, b, carry-in and op; outputs result bit and carry-out. The carry register stays in the top.

## Test plan

- SETTLE_CYCLES=0, ADD 0x1234+0x0FFF → result 0x2233, cout 0, `done` at t+17, 16 `res_valid` strobes with `sl` 0..15.
- SUB 0x0005−0x0007 → result 0xFFFE, cout 0. SUB 0x0007−0x0005 → 0x0002, cout 1.
- Flags on, ADD 0xFFFF+0x0001 → 0x0000, cout 1, zero 1, ovf 0. ADD 0x7FFF+0x0001 → 0x8000, ovf 1.
- SETTLE_CYCLES=2, XOR 0xA5A5^0x0FF0 → 0xAA55. Each `sl` value held 3 cycles; `done` at t+49.
- `start` pulsed at `sl`=5 during RUN → ignored, result unaffected. `rst` low at `sl`=7 → same cycle `busy`=0, `sl`=0, result 0. Next start completes normally.
- AND 0xF0F0&0x3C3C → 0x3030, cout 0, ovf 0. `start` held high through DONE → new operation accepted the cycle after `done`.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared constants and enums for the bit-serial ALU sequencer
package serial_alu_pkg;
    localparam int WIDTH = 16;
    localparam int SEL_W = 4;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_XOR, OP_AND} alu_op_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
endpackage

// File: rtl/serial_bit_alu.sv
// serial_bit_alu: combinational one-bit ALU slice; carry-out is 0 for logic ops
module serial_bit_alu
    import serial_alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    ci,
    input  alu_op_t op,
    output logic    r,
    output logic    co
);
    logic bx;
    always_comb begin
        bx = (op == OP_SUB) ? ~b : b;
        r  = (op == OP_XOR) ? a ^ b : (op == OP_AND) ? a & b : a ^ bx ^ ci;
        co = (op == OP_ADD || op == OP_SUB) ? (a & bx) | (ci & (a ^ bx)) : 1'b0;
    end
endmodule

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: walks mux select 0..15, computing one result bit per step.
// Define SERIAL_ALU_FLAGS_EN to enable the zero and ovf flags (tied to 0 otherwise).
module serial_alu_sequencer
    import serial_alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic [SEL_W-1:0] sl,
    output logic             busy,
    output logic             res_bit,
    output logic             res_valid,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);
    seq_state_t state;
    alu_op_t    op_q;
    logic [2:0] cnt;
    logic       carry, bit_r, bit_co, sample, last;

    serial_bit_alu u_bit (
        .a (a_bit),
        .b (b_bit),
        .ci(carry),
        .op(op_q),
        .r (bit_r),
        .co(bit_co)
    );

    assign sample    = (state == RUN) && (cnt == 3'(SETTLE_CYCLES));
    assign last      = sample && (sl == SEL_W'(WIDTH - 1));
    assign res_valid = sample;
    assign res_bit   = sample & bit_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            op_q   <= OP_ADD;
            cnt    <= '0;
            carry  <= 1'b0;
            sl     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= RUN;
                    op_q   <= alu_op_t'(op);
                    cnt    <= '0;
                    sl     <= '0;
                    busy   <= 1'b1;
                    result <= '0;
                    cout   <= 1'b0;
                    carry  <= (alu_op_t'(op) == OP_SUB);
                end
                RUN: if (sample) begin
                    result[sl] <= bit_r;
                    carry      <= bit_co;
                    cnt        <= '0;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= bit_co;
                    end else begin
                        sl <= sl + 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    sl    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    // carry still holds carry-into-MSB during the bit-15 sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (state == IDLE && start) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (last) begin
            zero <= ({bit_r, result[WIDTH-2:0]} == '0);
            ovf  <= carry ^ bit_co;
        end
    end
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb_serial_alu_sequencer: directed and random operations checked against an arithmetic model.
module tb_serial_alu_sequencer;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] opa = 16'h0, opb = 16'h0;
    logic        a_bit, b_bit;
    logic [3:0]  sl;
    logic        busy, res_bit, res_valid, done, cout, zero, ovf;
    logic [15:0] result;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    assign a_bit = opa[sl];
    assign b_bit = opb[sl];

    serial_alu_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a_bit(a_bit), .b_bit(b_bit),
        .sl(sl), .busy(busy), .res_bit(res_bit), .res_valid(res_valid), .done(done),
        .result(result), .cout(cout), .zero(zero), .ovf(ovf)
    );

    task automatic test_reset();
        #1;
        compared++;
        if ({sl, busy, res_bit, res_valid, done, result, cout, zero, ovf} !== 25'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got sl=%0d busy=%b rv=%b done=%b result=%h cout=%b zero=%b ovf=%b, want all 0",
                     sl, busy, res_valid, done, result, cout, zero, ovf);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({sl, busy, done, result} !== 22'd0) begin
            mismatched++;
            $display("FAIL reset_release: got sl=%0d busy=%b done=%b result=%h, want 0", sl, busy, done, result);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input int pulse_sl, input bit hold);
        logic [16:0] full;
        logic [15:0] er;
        logic        ec, ez, ev;
        int          strobes;
        bit          pulsed, fin;
        case (o)
            2'd0: begin full = {1'b0, a} + {1'b0, b}; ec = full[16]; end
            2'd1: begin full = {1'b0, a - b}; ec = (a >= b); end
            2'd2: begin full = {1'b0, a ^ b}; ec = 1'b0; end
            default: begin full = {1'b0, a & b}; ec = 1'b0; end
        endcase
        er = full[15:0];
        ez = (er == 16'h0);
        ev = (o == 2'd0) ? (a[15] == b[15]) && (er[15] != a[15]) :
             (o == 2'd1) ? (a[15] != b[15]) && (er[15] != a[15]) : 1'b0;
`ifndef SERIAL_ALU_FLAGS_EN
        ez = 1'b0;
        ev = 1'b0;
`endif
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_before_start: busy=%b, want 0", busy);
        end
        opa = a; opb = b; op = o; start = 1'b1;
        @(posedge clk);
        strobes = 0; pulsed = 0; fin = 0;
        for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (pulse_sl >= 0 && !pulsed && busy && sl == 4'(pulse_sl)) begin
                start = 1'b1;
                op = 2'($urandom);
                pulsed = 1;
            end
            if (done === 1'b1) begin
                fin = 1;
                compared++;
                if (cyc != 16 * (S + 1) + 1 || result !== er || cout !== ec || zero !== ez || ovf !== ev
                    || busy !== 1'b0 || sl !== 4'd15 || strobes != 16) begin
                    mismatched++;
                    $display("FAIL done_op%0d a=%h b=%h: cyc=%0d result=%h cout=%b zero=%b ovf=%b busy=%b sl=%0d strobes=%0d; want cyc=%0d result=%h cout=%b zero=%b ovf=%b busy=0 sl=15 strobes=16",
                             o, a, b, cyc, result, cout, zero, ovf, busy, sl, strobes,
                             16 * (S + 1) + 1, er, ec, ez, ev);
                end
            end else begin
                compared++;
                if (busy !== 1'b1 || sl !== 4'((cyc - 1) / (S + 1))) begin
                    mismatched++;
                    $display("FAIL run_state cyc=%0d: busy=%b sl=%0d, want busy=1 sl=%0d", cyc, busy, sl, (cyc - 1) / (S + 1));
                end
                if (res_valid === 1'b1) begin
                    compared++;
                    if (strobes > 15 || cyc != (strobes + 1) * (S + 1) || sl !== 4'(strobes) || res_bit !== er[strobes]) begin
                        mismatched++;
                        $display("FAIL strobe%0d: cyc=%0d sl=%0d res_bit=%b, want cyc=%0d sl=%0d res_bit=%b",
                                 strobes, cyc, sl, res_bit, (strobes + 1) * (S + 1), strobes, er[strobes[3:0]]);
                    end
                    strobes++;
                end
            end
        end
        if (!fin) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: done=%b, want 1 within 300 cycles", done);
        end
    endtask

    task automatic test_directed();
        do_op(2'd0, 16'h1234, 16'h0FFF, -1, 0);
        do_op(2'd1, 16'h0005, 16'h0007, -1, 0);
        do_op(2'd1, 16'h0007, 16'h0005, -1, 0);
        do_op(2'd0, 16'hFFFF, 16'h0001, -1, 0);
        do_op(2'd0, 16'h7FFF, 16'h0001, -1, 0);
        do_op(2'd1, 16'h8000, 16'h0001, -1, 0);
        do_op(2'd2, 16'hA5A5, 16'h0FF0, -1, 0);
        do_op(2'd3, 16'hF0F0, 16'h3C3C, -1, 0);
    endtask

    task automatic test_ignore_start();
        do_op(2'd0, 16'h4321, 16'h1111, 5, 0);
        do_op(2'd1, 16'h0100, 16'h0200, 5, 0);
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        @(negedge clk);
        opa = 16'hBEEF; opb = 16'h1234; op = 2'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (sl == 4'd7) hit = 1;
            else @(negedge clk);
        end
        compared++;
        if (!hit) begin
            mismatched++;
            $display("FAIL reset_mid_reach: sl=%0d, want 7", sl);
        end
        rst = 1'b0;
        #1;
        compared++;
        if (busy !== 1'b0 || sl !== 4'd0 || result !== 16'h0 || done !== 1'b0 || res_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid: busy=%b sl=%0d result=%h done=%b rv=%b, want all 0", busy, sl, result, done, res_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        do_op(2'd0, 16'hBEEF, 16'h1234, -1, 0);
    endtask

    task automatic test_back_to_back();
        do_op(2'd3, 16'hF0F0, 16'h3C3C, -1, 1);
        do_op(2'd0, 16'h00FF, 16'h0F01, -1, 1);
        start = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++)
            do_op(2'($urandom), 16'($urandom), 16'($urandom), (n % 4 == 0) ? int'($urandom_range(0, 15)) : -1, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
